i2c_target_regs: RTL and testbench
==================================

# i2c_target_regs

I2C target front-end and register file inside the user design. It sits directly downstream of the board-level SCL/SDA pins and consumes the `scl` input and bidirectional `sda` line. The top level supplies these on `uio_in[0]`/`uio_in[1]` and takes the open-drain drive back on `uio_out[1]`. It decodes 7-bit-addressed write/read transactions into a small byte register bank that configures the rest of the design.

## Interface
- `I2C_ADDR`, default 7'h2A: 7-bit target address.
- `NUM_REGS`, default 4: number of 8-bit registers; power of two, 2..16.
- `clk`  in  1: system clock, 32.768 kHz.
- `rst_n`  in  1: asynchronous, active-low reset.
- `ena`  in  1: block enable. When low, the FSM is forced to IDLE and `sda_out`=1. Registers are retained.
- `scl_in`  in  1: raw SCL, asynchronous.
- `sda_in`  in  1: raw SDA, asynchronous.
- `sda_out`  out  1: open-drain control. 0 pulls SDA low; 1 releases it.
- `reg_data`  out  8*NUM_REGS: flattened register bank; reg k is at bits [8k+7:8k].
- `wr_strobe`  out  1: one-cycle pulse when a register is written.
- `wr_index`  out  log2(NUM_REGS): index of the register written; valid with `wr_strobe`.
- `busy`  out  1: high from a START detect until a STOP or abort.

## Operation
- SCL and SDA each pass through a 2-FF synchronizer plus a previous-value register. Edges and levels are taken from the synchronized signals only.
- START: synchronized SDA falls while synchronized SCL is high in both the current and the previous sample.
- STOP: synchronized SDA rises under the same SCL condition.
- If SCL and SDA change in the same sample, this is neither START nor STOP.
- FSM states: IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_W, RDATA, MACK, WAIT_STOP.
- IDLE → ADDR on START. A START detected in any state also forces ADDR, which gives repeated-start support; the current byte is discarded and no partial write occurs.
- A STOP detected in any state → IDLE.
- ADDR: shift 8 bits, MSB first, sampled on each SCL rise.
  - Address match with R/W=0 → ACK_ADDR, then PTR.
  - Address match with R/W=1 → ACK_ADDR, then RDATA.
  - Mismatch → WAIT_STOP, no ACK; the block then ignores the bus until the next START or STOP.
- PTR: the received byte, masked to log2(NUM_REGS) bits, loads the pointer → ACK_PTR → WDATA.
- WDATA: the received byte is written to reg[ptr], `wr_strobe` pulses, and ptr increments modulo NUM_REGS → ACK_W → WDATA.
- RDATA: shift out reg[ptr] MSB first, then go to MACK. Ptr increments when the byte is loaded.
  - MACK samples SDA on the SCL rise. 0 (ACK) → RDATA with the next byte. 1 (NACK) → WAIT_STOP with SDA released.
- Reset values: `sda_out`=1, all regs=0, ptr=0, `wr_strobe`=0, `wr_index`=0, `busy`=0, state=IDLE.
- Asserting `rst_n` low mid-transaction releases SDA immediately (asynchronously).

## Timing
- SCL high and low phases must each be ≥4 `clk` cycles, so SCL ≤ ~4 kHz. Faster SCL is unsupported and may cause bits to be missed.
- Input-to-detect latency is 3 `clk` cycles (2-FF sync plus edge register).
- `sda_out` changes only in the `clk` cycle in which an SCL falling edge is detected. It never changes while SCL is high, except on reset or `ena` low.
- ACK: `sda_out`=0 from the SCL fall after the 8th bit. It is released at the next SCL fall, or replaced there by the first read bit (RDATA).
- Register write, `wr_strobe`, and `wr_index` all occur in the same cycle as the ACK_W drive; the strobe lasts exactly 1 cycle.
- In RDATA, after the 8th bit's SCL fall, SDA is released for MACK.

## Structure
- Shared package `i2c_pkg` holds:
  - the FSM state encoding (4-bit localparams);
  - the R/W bit constants (WRITE=0, READ=1);
  - the ACK level constant (ACK=0).
- One sub-module, `i2c_sync_edge`, is instantiated twice (SCL and SDA). It provides the 2-FF synchronizer and outputs `lvl`, `rise`, and `fall`.
- The FSM, shift register, pointer, and register bank live in `i2c_target_regs`.

## Test plan
- Write: S, 0x54, ptr 0x01, 0xA5, 0x3C, P → ACKs at all 4 byte slots; reg1=0xA5, reg2=0x3C; two `wr_strobe` pulses with `wr_index` 1 then 2.
- Read with pointer wrap: S, 0x54, ptr 0x03, Sr, 0x55, read 2 bytes (ACK, then NACK), P → returns reg3 then reg0. SDA must be released after the NACK.
- Wrong address: S, 0x40, 0x12, P → no ACK (`sda_out` stays 1), no `wr_strobe`, regs unchanged, `busy` falls at P.
- Abort mid-byte: S, 0x54, ptr 0x00, 4 data bits, P → reg0 unchanged, state IDLE, `sda_out`=1.
- Reset mid-ACK: pulse `rst_n` low while `sda_out`=0 → `sda_out`=1 immediately, all regs 0, `busy` 0.
- `ena`=0 during a write to a matching address → no ACK, regs retained at their prior values.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus-level constants.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ADDR      = 4'd1,
        ACK_ADDR  = 4'd2,
        PTR       = 4'd3,
        ACK_PTR   = 4'd4,
        WDATA     = 4'd5,
        ACK_W     = 4'd6,
        RDATA     = 4'd7,
        MACK      = 4'd8,
        WAIT_STOP = 4'd9
    } state_t;

    localparam logic WRITE = 1'b0;
    localparam logic READ  = 1'b1;
    localparam logic ACK   = 1'b0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one raw bus line, plus a previous-sample register
// used to report single-cycle rise/fall pulses alongside the synchronized level.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Idle I2C lines are high, so reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign lvl  = sync_reg;
    assign rise = sync_reg & ~prev_reg;
    assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target decoding 7-bit addressed writes/reads into a small byte register bank.
// All bus decisions are taken from synchronized SCL/SDA; SDA drive only moves on SCL falls.
module i2c_target_regs #(
    parameter logic [6:0] I2C_ADDR = 7'h2A,
    parameter int         NUM_REGS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        scl_in,
    input  logic                        sda_in,
    output logic                        sda_out,
    output logic [8*NUM_REGS-1:0]       reg_data,
    output logic                        wr_strobe,
    output logic [$clog2(NUM_REGS)-1:0] wr_index,
    output logic                        busy
);
    import i2c_pkg::*;

    localparam int IW = $clog2(NUM_REGS);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det;

    state_t         state_reg, state_next;
    logic [7:0]     shift_reg, shift_next;
    logic [3:0]     cnt_reg, cnt_next;
    logic [IW-1:0]  ptr_reg, ptr_next;
    logic [IW-1:0]  windex_reg, windex_next;
    logic           sda_reg, sda_next;
    logic           busy_reg, busy_next;
    logic           rw_reg, rw_next;
    logic           strobe_reg, strobe_next;
    logic           reg_we;
    logic           load;
    logic [7:0]     rd_byte;
    logic [7:0]     regs_reg [NUM_REGS];

    i2c_sync_edge u_scl (.clk(clk), .rst_n(rst_n), .d(scl_in),
                         .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall));
    i2c_sync_edge u_sda (.clk(clk), .rst_n(rst_n), .d(sda_in),
                         .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall));

    // SCL high now and not just risen means it was high in the previous sample too.
    assign start_det = sda_fall && scl_lvl && !scl_rise;
    assign stop_det  = sda_rise && scl_lvl && !scl_rise;

    always_comb begin
        state_next  = state_reg;
        shift_next  = shift_reg;
        cnt_next    = cnt_reg;
        ptr_next    = ptr_reg;
        windex_next = windex_reg;
        sda_next    = sda_reg;
        busy_next   = busy_reg;
        rw_next     = rw_reg;
        strobe_next = 1'b0;
        reg_we      = 1'b0;
        load        = 1'b0;
        rd_byte     = regs_reg[ptr_reg];

        if (!ena) begin
            state_next = IDLE;
            sda_next   = 1'b1;
            busy_next  = 1'b0;
        end else if (start_det) begin
            state_next = ADDR;
            cnt_next   = '0;
            sda_next   = 1'b1;
            busy_next  = 1'b1;
        end else if (stop_det) begin
            state_next = IDLE;
            sda_next   = 1'b1;
            busy_next  = 1'b0;
        end else begin
            case (state_reg)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_next = {shift_reg[6:0], sda_lvl};
                        cnt_next   = cnt_reg + 4'd1;
                    end else if (scl_fall && cnt_reg == 4'd8) begin
                        cnt_next = '0;
                        sda_next = ACK;
                        if (state_reg == ADDR) begin
                            if (shift_reg[7:1] == I2C_ADDR) begin
                                rw_next    = shift_reg[0];
                                state_next = ACK_ADDR;
                            end else begin
                                sda_next   = 1'b1;
                                state_next = WAIT_STOP;
                            end
                        end else if (state_reg == PTR) begin
                            ptr_next   = shift_reg[IW-1:0];
                            state_next = ACK_PTR;
                        end else begin
                            reg_we      = 1'b1;
                            strobe_next = 1'b1;
                            windex_next = ptr_reg;
                            ptr_next    = ptr_reg + IW'(1);
                            state_next  = ACK_W;
                        end
                    end
                end
                ACK_ADDR: begin
                    if (scl_fall) begin
                        if (rw_reg == READ) begin
                            load = 1'b1;
                        end else begin
                            sda_next   = 1'b1;
                            state_next = PTR;
                        end
                    end
                end
                ACK_PTR, ACK_W: begin
                    if (scl_fall) begin
                        sda_next   = 1'b1;
                        state_next = WDATA;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        cnt_next = cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_reg == 4'd8) begin
                            sda_next   = 1'b1;
                            state_next = MACK;
                        end else begin
                            shift_next = {shift_reg[6:0], 1'b0};
                            sda_next   = shift_reg[6];
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        shift_next = {shift_reg[6:0], sda_lvl};
                    end else if (scl_fall) begin
                        if (shift_reg[0] == ACK) begin
                            load = 1'b1;
                        end else begin
                            state_next = WAIT_STOP;
                        end
                    end
                end
                default: ;
            endcase

            // First read bit goes out on the same SCL fall that ends the preceding ACK.
            if (load) begin
                shift_next = rd_byte;
                sda_next   = rd_byte[7];
                ptr_next   = ptr_reg + IW'(1);
                cnt_next   = '0;
                state_next = RDATA;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            shift_reg  <= '0;
            cnt_reg    <= '0;
            ptr_reg    <= '0;
            windex_reg <= '0;
            sda_reg    <= 1'b1;
            busy_reg   <= 1'b0;
            rw_reg     <= WRITE;
            strobe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            shift_reg  <= shift_next;
            cnt_reg    <= cnt_next;
            ptr_reg    <= ptr_next;
            windex_reg <= windex_next;
            sda_reg    <= sda_next;
            busy_reg   <= busy_next;
            rw_reg     <= rw_next;
            strobe_reg <= strobe_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    regs_reg[gi] <= '0;
                end else if (reg_we && ptr_reg == IW'(gi)) begin
                    regs_reg[gi] <= shift_reg;
                end
            end
            assign reg_data[8*gi +: 8] = regs_reg[gi];
        end
    endgenerate

    assign sda_out   = sda_reg | ~ena;
    assign wr_strobe = strobe_reg;
    assign wr_index  = windex_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C controller drives the bus, results are
// checked against a directed table, hand-written corner sequences and a transaction-level model.
module tb_i2c_target_regs;

    localparam int H = 8;   // clk cycles per SCL phase

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ena = 1'b1;
    logic        scl = 1'b1;
    logic        msda = 1'b1;
    logic        sda_line;
    logic        sda_out;
    logic [31:0] reg_data;
    logic        wr_strobe;
    logic [1:0]  wr_index;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    assign sda_line = msda & sda_out;
    always #10 clk = ~clk;

    i2c_target_regs #(.I2C_ADDR(7'h2A), .NUM_REGS(4)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .scl_in(scl), .sda_in(sda_line),
        .sda_out(sda_out), .reg_data(reg_data), .wr_strobe(wr_strobe),
        .wr_index(wr_index), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus monitor: SDA drive must not move while SCL is held high; strobes are logged.
    int   strobe_q[$];
    int   viol = 0;
    logic prev_sda = 1'b1, prev_scl = 1'b1, prev_strobe = 1'b0, prev_ena = 1'b1;
    always @(negedge clk) begin
        if (rst_n && ena && prev_ena && scl && prev_scl && sda_out !== prev_sda) viol++;
        if (wr_strobe) begin
            strobe_q.push_back(int'(wr_index));
            if (prev_strobe) viol++;
        end
        prev_sda    <= sda_out;
        prev_scl    <= scl;
        prev_strobe <= wr_strobe;
        prev_ena    <= ena;
    end

    // Reference model at transaction level
    logic [7:0] m_regs [4];
    int         exp_strobe_q[$];

    function automatic logic [31:0] model_pack();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    task automatic model_txn(input bit rd, input logic [6:0] addr, input logic [7:0] ptr,
                             input int n, input logic [31:0] wdata,
                             output int acks, output logic [31:0] rdata);
        int p;
        p = int'(ptr) % 4;
        acks = 0;
        rdata = '0;
        if (addr != 7'h2A || !ena) begin
            if (rd) for (int i = 0; i < n; i++) rdata[8*i +: 8] = 8'hFF;
            return;
        end
        if (!rd) begin
            acks = 2 + n;
            for (int i = 0; i < n; i++) begin
                m_regs[p] = wdata[8*i +: 8];
                exp_strobe_q.push_back(p);
                p = (p + 1) % 4;
            end
        end else begin
            acks = 3;
            for (int i = 0; i < n; i++) begin
                rdata[8*i +: 8] = m_regs[p];
                p = (p + 1) % 4;
            end
        end
    endtask

    // Bit-level controller
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        msda = 1'b1; wait_clk(H);
        scl  = 1'b1; wait_clk(H);
        msda = 1'b0; wait_clk(H);
        scl  = 1'b0; wait_clk(H);
    endtask

    task automatic i2c_stop();
        msda = 1'b0; wait_clk(H);
        scl  = 1'b1; wait_clk(H);
        msda = 1'b1; wait_clk(H);
    endtask

    task automatic write_bit(input bit b);
        msda = b;    wait_clk(H);
        scl  = 1'b1; wait_clk(H);
        scl  = 1'b0; wait_clk(H);
    endtask

    task automatic read_bit(output bit b);
        msda = 1'b1; wait_clk(H);
        scl  = 1'b1; wait_clk(H/2);
        b    = sda_line; wait_clk(H/2);
        scl  = 1'b0; wait_clk(H);
    endtask

    task automatic write_byte(input logic [7:0] d, output bit ack);
        bit b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = (b == 1'b0);
    endtask

    task automatic read_byte(input bit last, output logic [7:0] d);
        bit b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(last);
    endtask

    task automatic run_txn(input bit rd, input logic [6:0] addr, input logic [7:0] ptr,
                           input int n, input logic [31:0] wdata,
                           output int acks, output logic [31:0] rdata);
        bit a;
        logic [7:0] b;
        acks = 0;
        rdata = '0;
        i2c_start();
        check("busy_after_start", {31'd0, busy}, {31'd0, ena});
        write_byte({addr, 1'b0}, a); acks += int'(a);
        write_byte(ptr, a);          acks += int'(a);
        if (!rd) begin
            for (int i = 0; i < n; i++) begin
                write_byte(wdata[8*i +: 8], a);
                acks += int'(a);
            end
        end else begin
            i2c_start();
            write_byte({addr, 1'b1}, a); acks += int'(a);
            for (int i = 0; i < n; i++) begin
                read_byte(i == n - 1, b);
                rdata[8*i +: 8] = b;
            end
            check("sda_released_after_nack", {31'd0, sda_out}, 32'd1);
        end
        i2c_stop();
        wait_clk(4);
        check("busy_after_stop", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_strobes(input string tag);
        check({tag, "_strobe_count"}, strobe_q.size(), exp_strobe_q.size());
        if (strobe_q.size() == exp_strobe_q.size())
            foreach (strobe_q[i]) check({tag, "_strobe_index"}, strobe_q[i], exp_strobe_q[i]);
        strobe_q.delete();
        exp_strobe_q.delete();
    endtask

    typedef struct {
        bit          rd;
        logic [6:0]  addr;
        logic [7:0]  ptr;
        int          n;
        logic [31:0] wdata;
        int          exp_acks;
        logic [31:0] exp_rdata;
        logic [31:0] exp_regs;
    } vec_t;

    initial begin
        vec_t        vecs [6];
        int          acks, m_acks;
        logic [31:0] rdata, m_rdata;
        bit          rd, a;
        logic [6:0]  addr;
        logic [7:0]  ptr;
        int          n;
        logic [31:0] wdata;
        bit          seen;

        vecs[0] = '{1'b0, 7'h2A, 8'h01, 2, 32'h0000_3CA5, 4, 32'h0,         32'h003C_A500};
        vecs[1] = '{1'b0, 7'h20, 8'h12, 0, 32'h0,         0, 32'h0,         32'h003C_A500};
        vecs[2] = '{1'b0, 7'h2A, 8'h03, 2, 32'h0000_1177, 4, 32'h0,         32'h773C_A511};
        vecs[3] = '{1'b1, 7'h2A, 8'h03, 2, 32'h0,         3, 32'h0000_1177, 32'h773C_A511};
        vecs[4] = '{1'b1, 7'h2A, 8'h05, 3, 32'h0,         3, 32'h0077_3CA5, 32'h773C_A511};
        vecs[5] = '{1'b0, 7'h2A, 8'hFE, 3, 32'h0003_0201, 5, 32'h0,         32'h0201_A503};
        foreach (m_regs[i]) m_regs[i] = 8'h00;

        wait_clk(5);
        check("reset_sda_out", {31'd0, sda_out}, 32'd1);
        check("reset_reg_data", reg_data, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_wr_strobe", {31'd0, wr_strobe}, 32'd0);
        check("reset_wr_index", {30'd0, wr_index}, 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        foreach (vecs[v]) begin
            model_txn(vecs[v].rd, vecs[v].addr, vecs[v].ptr, vecs[v].n, vecs[v].wdata, m_acks, m_rdata);
            run_txn(vecs[v].rd, vecs[v].addr, vecs[v].ptr, vecs[v].n, vecs[v].wdata, acks, rdata);
            $display("vec %0d rd=%0d addr=%h ptr=%h acks=%0d rdata=%h regs=%h",
                     v, vecs[v].rd, vecs[v].addr, vecs[v].ptr, acks, rdata, reg_data);
            check("table_acks", acks, vecs[v].exp_acks);
            check("table_rdata", rdata, vecs[v].exp_rdata);
            check("table_regs", reg_data, vecs[v].exp_regs);
            check_strobes("table");
        end

        // Abort in the middle of a data byte
        i2c_start();
        write_byte(8'h54, a);
        write_byte(8'h00, a);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        wait_clk(4);
        $display("abort mid-byte: regs=%h sda_out=%0d busy=%0d", reg_data, sda_out, busy);
        check("abort_regs", reg_data, model_pack());
        check("abort_sda_out", {31'd0, sda_out}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check_strobes("abort");

        // Disabled block must not respond to its own address
        ena = 1'b0;
        model_txn(1'b0, 7'h2A, 8'h00, 1, 32'h99, m_acks, m_rdata);
        run_txn(1'b0, 7'h2A, 8'h00, 1, 32'h99, acks, rdata);
        $display("ena low write: acks=%0d regs=%h", acks, reg_data);
        check("ena_low_acks", acks, m_acks);
        check("ena_low_regs", reg_data, model_pack());
        check_strobes("ena_low");
        ena = 1'b1;
        wait_clk(4);

        for (int t = 0; t < 10; t++) begin
            rd    = bit'($urandom_range(0, 1));
            addr  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h2A;
            ptr   = 8'($urandom);
            n     = int'($urandom_range(1, 4));
            wdata = $urandom;
            model_txn(rd, addr, ptr, n, wdata, m_acks, m_rdata);
            run_txn(rd, addr, ptr, n, wdata, acks, rdata);
            $display("rand %0d rd=%0d addr=%h ptr=%h n=%0d acks=%0d rdata=%h regs=%h",
                     t, rd, addr, ptr, n, acks, rdata, reg_data);
            check("rand_acks", acks, m_acks);
            check("rand_rdata", rdata, m_rdata);
            check("rand_regs", reg_data, model_pack());
            check_strobes("rand");
        end

        // Reset asserted while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(((8'h54 >> i) & 8'h01) != 8'h00);
        msda = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (sda_out == 1'b0) seen = 1'b1;
            else wait_clk(1);
        end
        check("mid_ack_drive_seen", {31'd0, seen}, 32'd1);
        rst_n = 1'b0;
        #1;
        $display("reset mid-ack: sda_out=%0d regs=%h busy=%0d", sda_out, reg_data, busy);
        check("mid_reset_sda_out", {31'd0, sda_out}, 32'd1);
        check("mid_reset_regs", reg_data, 32'd0);
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_wr_index", {30'd0, wr_index}, 32'd0);
        foreach (m_regs[i]) m_regs[i] = 8'h00;
        wait_clk(3);
        scl = 1'b1;
        wait_clk(H);
        rst_n = 1'b1;
        wait_clk(H);
        strobe_q.delete();

        model_txn(1'b0, 7'h2A, 8'h02, 1, 32'h5A, m_acks, m_rdata);
        run_txn(1'b0, 7'h2A, 8'h02, 1, 32'h5A, acks, rdata);
        $display("post-reset write: acks=%0d regs=%h", acks, reg_data);
        check("post_reset_acks", acks, m_acks);
        check("post_reset_regs", reg_data, model_pack());
        check_strobes("post_reset");

        check("bus_protocol_violations", viol, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
